// File: rtl/pc.sv
// Program counter: registered instruction address that advances every
// clock, with a synchronous load for jump/branch targets.
module pc #(
  parameter int                WIDTH       = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int                INCREMENT   = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             we,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INCREMENT);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Load wins over increment; the sum wraps modulo 2^WIDTH.
  always_comb begin
    count_d = count_q + STEP;
    unique case (1'b1)
      we:      count_d = data;
      default: count_d = count_q + STEP;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_pc.sv
// Directed bench for pc: reset, load, wrap, back-to-back loads,
// async reset mid-count and reset release.
module tb_pc;

  logic        clk;
  logic        nrst;
  logic        we;
  logic [15:0] data;
  logic [15:0] count;

  int tests;
  int fails;

  pc #(
    .WIDTH(16),
    .RESET_VALUE(16'h0000),
    .INCREMENT(1)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .we(we),
    .data(data),
    .count(count)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] exp);
    tests++;
    assert (count === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, count, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    nrst  = 1'b0;
    we    = 1'b0;
    data  = 16'h0000;

    #1 chk("rst_hold", 16'h0000);
    #4 nrst = 1'b1;
    #5 chk("rst_val", 16'h0000);

    @(negedge clk) chk("inc1", 16'h0001);
    @(negedge clk) chk("inc2", 16'h0002);
    @(negedge clk) chk("inc3", 16'h0003);
    @(negedge clk) chk("inc4", 16'h0004);

    we   = 1'b1;
    data = 16'hDEAD;
    #1 chk("no_comb_path", 16'h0004);
    @(negedge clk) chk("load_dead", 16'hDEAD);
    we = 1'b0;
    @(negedge clk) chk("ld_inc1", 16'hDEAE);
    @(negedge clk) chk("ld_inc2", 16'hDEAF);
    @(negedge clk) chk("ld_inc3", 16'hDEB0);
    @(negedge clk) chk("ld_inc4", 16'hDEB1);

    we   = 1'b1;
    data = 16'hFFFE;
    @(negedge clk) chk("wrap_ld", 16'hFFFE);
    we = 1'b0;
    @(negedge clk) chk("wrap_ffff", 16'hFFFF);
    @(negedge clk) chk("wrap_0000", 16'h0000);
    @(negedge clk) chk("wrap_0001", 16'h0001);

    we   = 1'b1;
    data = 16'h1234;
    @(negedge clk) chk("b2b_1234", 16'h1234);
    data = 16'h5678;
    @(negedge clk) chk("b2b_5678", 16'h5678);
    data = 16'h9ABC;
    @(negedge clk) chk("b2b_9abc", 16'h9ABC);
    we = 1'b0;
    @(negedge clk) chk("b2b_inc", 16'h9ABD);

    we   = 1'b1;
    data = 16'h0042;
    @(negedge clk) chk("ld_0042", 16'h0042);
    nrst = 1'b0;
    data = 16'hBEEF;
    #1 chk("async_rst", 16'h0000);
    @(posedge clk) #1 chk("rst_edge_we", 16'h0000);
    @(negedge clk) chk("rst_hold_we", 16'h0000);

    we   = 1'b0;
    nrst = 1'b1;
    #1 chk("rel_pre", 16'h0000);
    @(negedge clk) chk("rel_inc", 16'h0001);
    @(negedge clk) chk("rel_inc2", 16'h0002);

    #5 nrst = 1'b0;
    #1 chk("async_rst2", 16'h0000);
    @(negedge clk);
    we   = 1'b1;
    data = 16'h1357;
    nrst = 1'b1;
    @(negedge clk) chk("rel_load", 16'h1357);
    we = 1'b0;
    @(negedge clk) chk("rel_load_inc", 16'h1358);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
